// File: rtl/hpdcache_victim_sel_ctrl.sv
// Victim-selection sequencer: round-robin arbitration among allocation requesters,
// directory read, victim pick, response handshake and replacement commit.
// Optional performance counters are enabled by defining HPDCACHE_VICTIM_SEL_CTRL_PERF_EN.
module hpdcache_victim_sel_ctrl #(
  parameter int NREQ  = 2,
  parameter int SET_W = 7,
  parameter int WAYS  = 4,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*SET_W-1:0]  req_set_i,
  output logic [NREQ-1:0]        req_ready_o,
  output logic                   rsp_valid_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [WAYS-1:0]        rsp_way_o,
  output logic                   rsp_dirty_o,
  input  logic                   rsp_ready_i,
  output logic                   dir_rd_o,
  output logic [SET_W-1:0]       dir_set_o,
  input  logic [WAYS-1:0]        dir_valid_i,
  input  logic [WAYS-1:0]        dir_dirty_i,
  input  logic [WAYS-1:0]        dir_fetch_i,
  output logic                   sel_victim_o,
  input  logic [WAYS-1:0]        sel_way_i,
  output logic                   repl_o,
  output logic [SET_W-1:0]       repl_set_o,
  output logic [WAYS-1:0]        repl_way_o,
  output logic                   busy_o
`ifdef HPDCACHE_VICTIM_SEL_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_sel_cnt_o,
  output logic [31:0]            perf_dirty_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    DIR,
    RSP
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [WAYS-1:0]  way_q, way_d;
  logic             dirty_q, dirty_d;

  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [SET_W-1:0] grant_set;
  logic             handshake;

  // Round-robin search: first requester at or above the pointer, else the lowest one below it.
  always_comb begin
    logic            found_hi;
    logic            found_lo;
    logic [ID_W-1:0] idx_hi;
    logic [ID_W-1:0] idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid_i[k] && !found_hi && (ID_W'(k) >= ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(k);
      end
      if (req_valid_i[k] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(k);
      end
    end
    grant_found = found_hi | found_lo;
    grant_idx   = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    grant_set = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == grant_idx) grant_set = req_set_i[k*SET_W +: SET_W];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    set_d        = set_q;
    way_d        = way_q;
    dirty_d      = dirty_q;
    handshake    = 1'b0;
    req_ready_o  = '0;
    rsp_valid_o  = 1'b0;
    rsp_id_o     = '0;
    rsp_way_o    = '0;
    rsp_dirty_o  = 1'b0;
    dir_rd_o     = 1'b0;
    dir_set_o    = '0;
    sel_victim_o = 1'b0;
    repl_o       = 1'b0;
    repl_set_o   = '0;
    repl_way_o   = '0;
    busy_o       = 1'b0;

    // While reset is held every output stays quiet, so an abandoned response never commits.
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
            id_d      = grant_idx;
            set_d     = grant_set;
            dir_rd_o  = 1'b1;
            dir_set_o = grant_set;
            state_d   = DIR;
          end
        end

        DIR: begin
          busy_o       = 1'b1;
          sel_victim_o = 1'b1;
          if (|(dir_fetch_i & sel_way_i)) begin
            // Chosen way is mid-refill: read the set again and pick anew next cycle.
            dir_rd_o  = 1'b1;
            dir_set_o = set_q;
          end else begin
            way_d   = sel_way_i;
            dirty_d = |(sel_way_i & dir_valid_i & dir_dirty_i);
            state_d = RSP;
          end
        end

        RSP: begin
          busy_o      = 1'b1;
          rsp_valid_o = 1'b1;
          rsp_id_o    = id_q;
          rsp_way_o   = way_q;
          rsp_dirty_o = dirty_q;
          if (rsp_ready_i) begin
            handshake  = 1'b1;
            repl_o     = 1'b1;
            repl_set_o = set_q;
            repl_way_o = way_q;
            ptr_d      = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
            state_d    = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      set_q   <= '0;
      way_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      set_q   <= set_d;
      way_q   <= way_d;
      dirty_q <= dirty_d;
    end
  end

`ifdef HPDCACHE_VICTIM_SEL_CTRL_PERF_EN
  logic [31:0] sel_cnt_q, sel_cnt_d;
  logic [31:0] dirty_cnt_q, dirty_cnt_d;

  // Saturating event counters.
  always_comb begin
    sel_cnt_d   = sel_cnt_q;
    dirty_cnt_d = dirty_cnt_q;
    if (handshake && (sel_cnt_q != '1)) sel_cnt_d = sel_cnt_q + 32'd1;
    if (handshake && dirty_q && (dirty_cnt_q != '1)) dirty_cnt_d = dirty_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_cnt_q   <= '0;
      dirty_cnt_q <= '0;
    end else begin
      sel_cnt_q   <= sel_cnt_d;
      dirty_cnt_q <= dirty_cnt_d;
    end
  end

  assign perf_sel_cnt_o   = sel_cnt_q;
  assign perf_dirty_cnt_o = dirty_cnt_q;
`endif

endmodule

// File: tb/tb_hpdcache_victim_sel_ctrl.sv
// Self-checking bench for hpdcache_victim_sel_ctrl: directed scenarios plus randomized
// transactions against a transaction-level round-robin model.
module tb_hpdcache_victim_sel_ctrl;

  localparam int NREQ  = 2;
  localparam int SET_W = 7;
  localparam int WAYS  = 4;

  logic                  clk_i;
  logic                  rst_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*SET_W-1:0] req_set_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_id_o;
  logic [WAYS-1:0]       rsp_way_o;
  logic                  rsp_dirty_o;
  logic                  rsp_ready_i;
  logic                  dir_rd_o;
  logic [SET_W-1:0]      dir_set_o;
  logic [WAYS-1:0]       dir_valid_i;
  logic [WAYS-1:0]       dir_dirty_i;
  logic [WAYS-1:0]       dir_fetch_i;
  logic                  sel_victim_o;
  logic [WAYS-1:0]       sel_way_i;
  logic                  repl_o;
  logic [SET_W-1:0]      repl_set_o;
  logic [WAYS-1:0]       repl_way_o;
  logic                  busy_o;
`ifdef HPDCACHE_VICTIM_SEL_CTRL_PERF_EN
  logic [31:0]           perf_sel_cnt_o;
  logic [31:0]           perf_dirty_cnt_o;
`endif

  hpdcache_victim_sel_ctrl #(
    .NREQ (NREQ),
    .SET_W(SET_W),
    .WAYS (WAYS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_set_i   (req_set_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_way_o   (rsp_way_o),
    .rsp_dirty_o (rsp_dirty_o),
    .rsp_ready_i (rsp_ready_i),
    .dir_rd_o    (dir_rd_o),
    .dir_set_o   (dir_set_o),
    .dir_valid_i (dir_valid_i),
    .dir_dirty_i (dir_dirty_i),
    .dir_fetch_i (dir_fetch_i),
    .sel_victim_o(sel_victim_o),
    .sel_way_i   (sel_way_i),
    .repl_o      (repl_o),
    .repl_set_o  (repl_set_o),
    .repl_way_o  (repl_way_o),
    .busy_o      (busy_o)
`ifdef HPDCACHE_VICTIM_SEL_CTRL_PERF_EN
    ,
    .perf_sel_cnt_o  (perf_sel_cnt_o),
    .perf_dirty_cnt_o(perf_dirty_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: round-robin pointer and completion counters.
  int rr_ptr       = 0;
  int exp_sel_cnt  = 0;
  int exp_dirty    = 0;
  int last_repl    = -1;
  int dir_rd_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [30:0] all_outputs();
    return {req_ready_o, rsp_valid_o, rsp_id_o, rsp_way_o, rsp_dirty_o, dir_rd_o, dir_set_o,
            sel_victim_o, repl_o, repl_set_o, repl_way_o, busy_o};
  endfunction

  function automatic logic [WAYS-1:0] rand_onehot();
    return 4'b0001 << $urandom_range(0, WAYS - 1);
  endfunction

  task automatic randomize_side();
    dir_valid_i = 4'($urandom);
    dir_dirty_i = 4'($urandom);
    dir_fetch_i = 4'($urandom);
    sel_way_i   = rand_onehot();
  endtask

  // One complete allocation, starting in an IDLE cycle and ending after the handshake edge.
  task automatic run_txn(input logic [1:0] valid, input logic [SET_W-1:0] s0, input logic [SET_W-1:0] s1,
                         input int n_conf, input logic [WAYS-1:0] way_fin, input logic [WAYS-1:0] dv,
                         input logic [WAYS-1:0] dd, input int hold, output int winner);
    int w;
    logic [SET_W-1:0] exp_set;
    logic exp_dirty_bit;
    logic [WAYS-1:0] wy;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      if (w < 0 && valid[(rr_ptr + i) % NREQ]) w = (rr_ptr + i) % NREQ;
    end
    exp_set = (w == 0) ? s0 : s1;
    exp_dirty_bit = |(way_fin & dv & dd);
    dir_rd_count = 0;

    req_valid_i = valid;
    req_set_i   = {s1, s0};
    rsp_ready_i = 1'b0;
    randomize_side();
    #1;
    check("grant_onehot", req_ready_o, 2'b01 << w);
    check("grant_dir_rd", dir_rd_o, 1'b1);
    check("grant_dir_set", dir_set_o, exp_set);
    check("idle_busy", busy_o, 1'b0);
    if (dir_rd_o) dir_rd_count++;
    tick();

    for (int c = 0; c <= n_conf; c++) begin
      wy          = (c < n_conf) ? rand_onehot() : way_fin;
      dir_valid_i = dv;
      dir_dirty_i = dd;
      sel_way_i   = wy;
      dir_fetch_i = (c < n_conf) ? (wy | 4'($urandom)) : (4'($urandom) & ~wy);
      #1;
      check("dir_sel_victim", sel_victim_o, 1'b1);
      check("dir_busy", busy_o, 1'b1);
      check("dir_no_rsp", rsp_valid_o, 1'b0);
      check("dir_no_grant", req_ready_o, 2'b00);
      check("dir_reissue", dir_rd_o, (c < n_conf));
      if (c < n_conf) check("dir_reissue_set", dir_set_o, exp_set);
      if (dir_rd_o) dir_rd_count++;
      tick();
    end
    check("dir_rd_strobes", dir_rd_count, n_conf + 1);

    for (int h = 0; h <= hold; h++) begin
      rsp_ready_i = (h == hold);
      randomize_side();
      #1;
      check("rsp_valid", rsp_valid_o, 1'b1);
      check("rsp_id", rsp_id_o, w);
      check("rsp_way", rsp_way_o, way_fin);
      check("rsp_dirty", rsp_dirty_o, exp_dirty_bit);
      check("rsp_no_grant", req_ready_o, 2'b00);
      check("rsp_repl", repl_o, (h == hold));
      if (h == hold) begin
        check("repl_set", repl_set_o, exp_set);
        check("repl_way", repl_way_o, way_fin);
        last_repl = cyc;
      end
      tick();
    end
    rsp_ready_i = 1'b0;
    rr_ptr = (w + 1) % NREQ;
    exp_sel_cnt++;
    if (exp_dirty_bit) exp_dirty++;
    winner = w;
  endtask

  initial begin
    int w;
    int prev_w;
    int prev_repl;
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_set_i   = '0;
    rsp_ready_i = 1'b0;
    dir_valid_i = '0;
    dir_dirty_i = '0;
    dir_fetch_i = '0;
    sel_way_i   = '0;
    tick();
    tick();
    check("reset_outputs_held", all_outputs(), '0);
    rst_i = 1'b0;
    #1;
    check("reset_outputs_idle", all_outputs(), '0);
    tick();

    // Single request on requester 0, set 5, dirty victim in way 2.
    run_txn(2'b01, 7'd5, 7'd0, 0, 4'b0100, 4'b1111, 4'b0100, 0, w);
    check("single_winner", w, 0);

    // Both requesters held valid: grants alternate, replacements every 3 cycles.
    prev_w = w;
    prev_repl = last_repl;
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 7'($urandom), 7'($urandom), 0, rand_onehot(), 4'($urandom), 4'($urandom), 0, w);
      check("rr_alternate", w, 1 - prev_w);
      if (i > 0) check("repl_spacing", last_repl - prev_repl, 3);
      prev_w = w;
      prev_repl = last_repl;
    end

    // Fetch conflict once, then way 1 is accepted.
    run_txn(2'b01, 7'd33, 7'd0, 1, 4'b0010, 4'b1111, 4'b0000, 0, w);

    // Consumer stalls for 10 cycles.
    run_txn(2'b10, 7'd0, 7'd99, 0, 4'b1000, 4'b1000, 4'b1000, 10, w);

    // Reset while in RSP: pointer is 0 now, so move it to 1 first.
    run_txn(2'b01, 7'd12, 7'd0, 0, 4'b0001, 4'b0000, 4'b0000, 0, w);
    req_valid_i = 2'b11;
    req_set_i   = {7'd44, 7'd22};
    #1;
    check("pre_rst_grant", req_ready_o, 2'b10);
    tick();
    dir_fetch_i = '0;
    sel_way_i   = 4'b0100;
    tick();
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    rst_i       = 1'b1;
    #1;
    check("rst_no_repl", repl_o, 1'b0);
    tick();
    rst_i       = 1'b0;
    rsp_ready_i = 1'b0;
    #1;
    check("post_rst_outputs", all_outputs(), '0);
    rr_ptr = 0;
    tick();
    run_txn(2'b11, 7'd7, 7'd8, 0, 4'b0010, 4'b0010, 4'b0010, 0, w);
    check("post_rst_winner", w, 0);

    // Randomized transactions.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(1, 3));
      run_txn(v, 7'($urandom), 7'($urandom), $urandom_range(0, 2), rand_onehot(),
              4'($urandom), 4'($urandom), $urandom_range(0, 3), w);
    end

    // Idle with no requests: nothing moves.
    req_valid_i = '0;
    #1;
    check("final_idle", all_outputs(), '0);

`ifdef HPDCACHE_VICTIM_SEL_CTRL_PERF_EN
    check("perf_sel_cnt", perf_sel_cnt_o, exp_sel_cnt);
    check("perf_dirty_cnt", perf_dirty_cnt_o, exp_dirty);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hpdcache_victim_sel_ctrl.md
Name: hpdcache_victim_sel_ctrl

Overview:
- Sequences the shared victim-selection resource of the HPDcache. Several allocation requesters (refill, prefetch, CMO) need a victim way; this block arbitrates among them round-robin.
- For the winning request it reads the directory state of the target set, pulses the victim selector and captures the returned way. It returns the way to the requester, then commits the replacement update to the replacement policy.
- Sits between the miss/refill handlers and the victim selector plus directory read port.

Parameters:
- NREQ, 2, number of requesters (2..8).
- SET_W, 7, width of the set index.
- WAYS, 4, associativity; the way vector width equals WAYS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NREQ  per-requester allocation request.
- req_set_i  in  NREQ*SET_W  per-requester set index (requester k at bits [k*SET_W +: SET_W]).
- req_ready_o  out  NREQ  one-hot grant/accept.
- rsp_valid_o  out  1  victim way available.
- rsp_id_o  out  $clog2(NREQ) (min 1)  requester index of the response.
- rsp_way_o  out  WAYS  one-hot victim way.
- rsp_dirty_o  out  1  chosen victim is valid and dirty (write-back needed).
- rsp_ready_i  in  1  response consumed.
- dir_rd_o  out  1  directory read strobe.
- dir_set_o  out  SET_W  directory read set.
- dir_valid_i, dir_dirty_i, dir_fetch_i  in  WAYS each  directory state; valid exactly 1 cycle after dir_rd_o.
- sel_victim_o  out  1  selection strobe to the victim selector.
- sel_way_i  in  WAYS  victim way (combinational from the selector).
- repl_o  out  1  replacement-commit pulse.
- repl_set_o  out  SET_W  set of the committed replacement.
- repl_way_o  out  WAYS  way of the committed replacement.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: FSM=IDLE, RR pointer=0. All outputs 0: req_ready_o, rsp_valid_o, rsp_id_o, rsp_way_o, rsp_dirty_o, dir_rd_o, dir_set_o, sel_victim_o, repl_o, repl_set_o, repl_way_o, busy_o.
- IDLE: if any req_valid_i is set:
  - Grant the first requester at or after the RR pointer (wrapping modulo NREQ); req_ready_o one-hot for that cycle only.
  - Latch set and id; drive dir_rd_o=1 and dir_set_o=set in the same cycle.
  - Next state DIR.
- DIR (1 cycle): directory data is valid.
  - Assert sel_victim_o=1 and feed dir_* through to the selector.
  - Latch sel_way_i into way_q.
  - rsp_dirty = |(sel_way_i & dir_valid_i & dir_dirty_i).
  - If dir_fetch_i & sel_way_i is nonzero (way already being refilled), do not latch; re-issue dir_rd_o for the same set and stay in DIR. Retry at most every cycle.
  - Otherwise go to RSP.
- RSP: rsp_valid_o=1 with rsp_id_o, rsp_way_o and rsp_dirty_o held stable until rsp_ready_i.
  - On handshake: repl_o=1 for exactly 1 cycle, with repl_set_o=set and repl_way_o=way_q.
  - RR pointer advances to winner+1 (wraps to 0 after NREQ-1).
  - Next state IDLE.
- Minimum latency: grant in cycle 0; rsp_valid_o in cycle 2; repl_o in the handshake cycle.
- One request in flight at a time; req_ready_o=0 in all states except IDLE.
- No back-to-back grant: the cycle after RSP exits, the block is in IDLE and may grant.
- A requester dropping req_valid_i without a grant is legal. After a grant it cannot withdraw.
- Reset mid-operation: abandon the current request immediately. No repl_o is emitted. All outputs return to reset values on the next edge.
- One-hot invariants: req_ready_o, rsp_way_o and repl_way_o are each zero or one-hot.

Optional Feature:
- Macro: HPDCACHE_VICTIM_SEL_CTRL_PERF_EN.
- When defined, adds two output ports:
  - perf_sel_cnt_o (32 bits): increments on each RSP handshake.
  - perf_dirty_cnt_o (32 bits): increments on each RSP handshake with rsp_dirty_o=1.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single request, req0 set=5, selector returns 4'b0100, dir_valid=4'b1111, dir_dirty=4'b0100 -> dir_rd_o at cycle 0 with set 5; rsp_valid_o at cycle 2 with way=4'b0100, dirty=1, id=0; repl_o pulse with set=5, way=4'b0100 on the handshake.
- req0 and req1 both valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; each repl_o is 3 cycles apart.
- Fetch conflict: first selection returns way 4'b0001 with dir_fetch=4'b0001, second returns 4'b0010 -> exactly 2 dir_rd_o strobes; response way=4'b0010.
- rsp_ready_i held low for 10 cycles -> rsp_valid_o and its payload stable; no repl_o and no new grants until the handshake.
- rst_i asserted while in RSP -> next cycle all outputs 0; no repl_o emitted; a subsequent request completes normally with RR pointer=0.
- With PERF_EN: 3 completions, 1 of them dirty -> perf_sel_cnt_o=3, perf_dirty_cnt_o=1.
